aes_block_sequencer: RTL

Host-side initiator for the AES cipher/inverse-cipher cores. Accepts one 128-bit block plus key and mode over a valid/ready stream, drives the core's `ld`/`key`/`text_in` inputs, waits for the core's `done`, and returns `text_out` over a valid/ready result stream. A per-block watchdog converts a missing `done` into an error-tagged result. It sits between the system bus logic and the mode-selected AES core, which shares its clock and reset.

---
 rtl/aes_block_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: issues one block at a time to an AES core, waits for
// its done pulse (or a watchdog timeout) and returns the result over a
// valid/ready stream. Also keeps handed-off block and timeout counters.
module aes_block_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         s_mode,
   input  logic [127:0] s_key,
   input  logic [127:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_mode,
   output logic         m_err,
   output logic         core_ld,
   output logic         core_mode,
   output logic [127:0] core_key,
   output logic [127:0] core_text_in,
   input  logic [127:0] core_text_out,
   input  logic         core_done,
   output logic         busy,
   output logic [15:0]  blk_cnt,
   output logic [7:0]   err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // Last watchdog value before a timeout is declared.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [7:0]    wd_q, wd_d;
   logic          m_valid_q, m_valid_d;
   logic [127:0]  m_data_q, m_data_d;
   logic          m_mode_q, m_mode_d;
   logic          m_err_q, m_err_d;
   logic          core_mode_q, core_mode_d;
   logic [127:0]  core_key_q, core_key_d;
   logic [127:0]  core_text_in_q, core_text_in_d;
   logic [15:0]   blk_cnt_q, blk_cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          ready_c;
   logic          accept_c;

   // Next-state, handshake and datapath update logic.
   always_comb begin
      state_d        = state_q;
      wd_d           = wd_q;
      m_valid_d      = m_valid_q;
      m_data_d       = m_data_q;
      m_mode_d       = m_mode_q;
      m_err_d        = m_err_q;
      core_mode_d    = core_mode_q;
      core_key_d     = core_key_q;
      core_text_in_d = core_text_in_q;
      blk_cnt_d      = blk_cnt_q;
      err_cnt_d      = err_cnt_q;
      ready_c        = 1'b0;
      accept_c       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (s_valid) begin
               accept_c = 1'b1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // core_ld is asserted for this single cycle; arm the watchdog.
            wd_d    = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done pulse coinciding with the timeout still yields a result.
            if (core_done) begin
               m_data_d  = core_text_out;
               m_err_d   = 1'b0;
               m_mode_d  = core_mode_q;
               m_valid_d = 1'b1;
               state_d   = ST_OUT;
            end else if (wd_q == WD_LAST) begin
               m_data_d  = '0;
               m_err_d   = 1'b1;
               m_mode_d  = core_mode_q;
               m_valid_d = 1'b1;
               state_d   = ST_OUT;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         ST_OUT: begin
            // Handoff frees the slot, so a new request can be taken in the same cycle.
            if (m_ready) begin
               ready_c   = 1'b1;
               m_valid_d = 1'b0;
               if (!m_err_q) begin
                  blk_cnt_d = blk_cnt_q + 16'd1;
               end else if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               if (s_valid) begin
                  accept_c = 1'b1;
                  state_d  = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept_c) begin
         core_mode_d    = s_mode;
         core_key_d     = s_key;
         core_text_in_d = s_data;
      end
   end

   // State and datapath registers; reset aborts any block in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         wd_q           <= 8'd0;
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_mode_q       <= 1'b0;
         m_err_q        <= 1'b0;
         core_mode_q    <= 1'b0;
         core_key_q     <= '0;
         core_text_in_q <= '0;
         blk_cnt_q      <= 16'd0;
         err_cnt_q      <= 8'd0;
      end else begin
         state_q        <= state_d;
         wd_q           <= wd_d;
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_mode_q       <= m_mode_d;
         m_err_q        <= m_err_d;
         core_mode_q    <= core_mode_d;
         core_key_q     <= core_key_d;
         core_text_in_q <= core_text_in_d;
         blk_cnt_q      <= blk_cnt_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   // Ready is forced low while reset is held so nothing is accepted then.
   assign s_ready      = rst & ready_c;
   assign core_ld      = (state_q == ST_LOAD);
   assign busy         = (state_q == ST_LOAD) || (state_q == ST_WAIT);
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_mode       = m_mode_q;
   assign m_err        = m_err_q;
   assign core_mode    = core_mode_q;
   assign core_key     = core_key_q;
   assign core_text_in = core_text_in_q;
   assign blk_cnt      = blk_cnt_q;
   assign err_cnt      = err_cnt_q;

endmodule
